// File: rtl/halut_pkg.sv
// Shared HALUT types and default dimensions used by the encoder and decoder.
// Also holds the FP16 classification helpers used by the threshold comparator.
package halut_pkg;

    localparam int unsigned K_DEFAULT       = 16;
    localparam int unsigned C_DEFAULT       = 32;
    localparam int unsigned DATA_TYPE_WIDTH = 16;

    typedef logic [15:0] fp16_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WALK = 1'b1
    } enc_state_e;

    function automatic logic fp16_is_nan(input fp16_t v);
        return (v[14:10] == 5'h1f) && (v[9:0] != 10'h000);
    endfunction

    function automatic logic fp16_is_zero(input fp16_t v);
        return (v[14:0] == 15'h0000);
    endfunction

endpackage

// File: rtl/fp16_greater_than.sv
// Combinational strict FP16 a > b: NaN operands and signed zeros never compare greater,
// infinities are ordered like any other magnitude.
module fp16_greater_than
    import halut_pkg::*;
(
    input  fp16_t a_i,
    input  fp16_t b_i,
    output logic  gt_o
);

    logic [14:0] a_mag_s;
    logic [14:0] b_mag_s;

    assign a_mag_s = a_i[14:0];
    assign b_mag_s = b_i[14:0];

    // Sign-magnitude ordering; for two negatives the smaller magnitude is the greater value.
    always_comb begin
        gt_o = 1'b0;
        if (fp16_is_nan(a_i) || fp16_is_nan(b_i)) begin
            gt_o = 1'b0;
        end else if (fp16_is_zero(a_i) && fp16_is_zero(b_i)) begin
            gt_o = 1'b0;
        end else if (a_i[15] != b_i[15]) begin
            gt_o = ~a_i[15];
        end else if (!a_i[15]) begin
            gt_o = (a_mag_s > b_mag_s);
        end else begin
            gt_o = (a_mag_s < b_mag_s);
        end
    end

endmodule

// File: rtl/halut_encoder.sv
// HALUT tree encoder: walks a per-codebook balanced FP16 decision tree, one level per
// cycle, and emits (codebook, prototype index) pairs in codebook order.
module halut_encoder
    import halut_pkg::*;
#(
    parameter int unsigned K              = K_DEFAULT,
    parameter int unsigned C              = C_DEFAULT,
    parameter int unsigned DataTypeWidth  = DATA_TYPE_WIDTH,
    parameter int unsigned TotalAddrWidth = $clog2(C * K),
    parameter int unsigned CAddrWidth     = $clog2(C),
    parameter int unsigned TreeDepth      = $clog2(K)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [TotalAddrWidth-1:0]          waddr_i,
    input  logic [DataTypeWidth-1:0]           wdata_i,
    input  logic                               we_i,
    input  logic                               en_i,
    input  logic                               valid_i,
    output logic                               ready_o,
    input  logic [TreeDepth*DataTypeWidth-1:0] data_i,
    output logic [CAddrWidth-1:0]              c_addr_o,
    output logic [TreeDepth-1:0]               k_addr_o,
    output logic                               valid_o,
    output logic                               last_o
);

    localparam int unsigned LevelWidth = (TreeDepth > 1) ? $clog2(TreeDepth) : 1;
    localparam int unsigned NumThr     = C * K;
    localparam logic [LevelWidth-1:0] LastLevel = LevelWidth'(TreeDepth - 1);

    enc_state_e                         state_q, state_d;
    logic [LevelWidth-1:0]              level_q, level_d;
    logic [TreeDepth-1:0]               node_q, node_d;
    logic [TreeDepth-1:0]               kbits_q, kbits_d;
    logic [TreeDepth*DataTypeWidth-1:0] data_q, data_d;
    logic [CAddrWidth-1:0]              c_cnt_q, c_cnt_d;
    logic [CAddrWidth-1:0]              c_addr_q, c_addr_d;
    logic [TreeDepth-1:0]               k_addr_q, k_addr_d;
    logic                               valid_q, valid_d;
    logic                               last_q, last_d;
    logic [DataTypeWidth-1:0]           thr_q [NumThr];
    logic [DataTypeWidth-1:0]           thr_d [NumThr];

    logic                               thr_we_s;
    fp16_t                              x_s;
    fp16_t                              thr_rd_s;
    logic                               go_right_s;
    logic                               ready_s;
    logic [CAddrWidth-1:0]              c_cnt_inc_s;

    // Node K-1 of each codebook has no tree position, so writes to it are dropped.
    assign thr_we_s    = we_i && (waddr_i[TreeDepth-1:0] != TreeDepth'(K - 1));
    assign thr_rd_s    = thr_q[{c_cnt_q, node_q}];
    assign x_s         = data_q[level_q*DataTypeWidth +: DataTypeWidth];
    assign c_cnt_inc_s = (c_cnt_q == CAddrWidth'(C - 1)) ? {CAddrWidth{1'b0}}
                                                         : c_cnt_q + CAddrWidth'(1);

    fp16_greater_than u_gt (
        .a_i  (x_s),
        .b_i  (thr_rd_s),
        .gt_o (go_right_s)
    );

    // Threshold store next value: one write port, reads see the pre-edge contents.
    always_comb begin
        for (int i = 0; i < NumThr; i++) begin
            thr_d[i] = (thr_we_s && (waddr_i == TotalAddrWidth'(i))) ? wdata_i : thr_q[i];
        end
    end

    // Tree-walk FSM: next state, datapath updates and registered-output next values.
    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        node_d   = node_q;
        kbits_d  = kbits_q;
        data_d   = data_q;
        c_cnt_d  = c_cnt_q;
        c_addr_d = c_addr_q;
        k_addr_d = k_addr_q;
        valid_d  = 1'b0;
        last_d   = 1'b0;
        ready_s  = 1'b0;

        if (!en_i) begin
            state_d = IDLE;
            c_cnt_d = {CAddrWidth{1'b0}};
            level_d = {LevelWidth{1'b0}};
            node_d  = {TreeDepth{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    ready_s = 1'b1;
                    if (valid_i) begin
                        data_d  = data_i;
                        level_d = {LevelWidth{1'b0}};
                        node_d  = {TreeDepth{1'b0}};
                        state_d = WALK;
                    end else begin
                        state_d = IDLE;
                    end
                end
                WALK: begin
                    node_d  = {node_q[TreeDepth-2:0], 1'b0} + TreeDepth'(1) + TreeDepth'(go_right_s);
                    kbits_d = {kbits_q[TreeDepth-2:0], go_right_s};
                    if (level_q != LastLevel) begin
                        level_d = level_q + LevelWidth'(1);
                    end else begin
                        // Emit, and accept the next vector in the same edge to stream.
                        ready_s  = 1'b1;
                        k_addr_d = {kbits_q[TreeDepth-2:0], go_right_s};
                        c_addr_d = c_cnt_q;
                        valid_d  = 1'b1;
                        last_d   = (c_cnt_q == CAddrWidth'(C - 1));
                        c_cnt_d  = c_cnt_inc_s;
                        level_d  = {LevelWidth{1'b0}};
                        node_d   = {TreeDepth{1'b0}};
                        if (valid_i) begin
                            data_d  = data_i;
                            state_d = WALK;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    level_d = {LevelWidth{1'b0}};
                    node_d  = {TreeDepth{1'b0}};
                end
            endcase
        end
    end

    // State, datapath, output and threshold registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            level_q  <= {LevelWidth{1'b0}};
            node_q   <= {TreeDepth{1'b0}};
            kbits_q  <= {TreeDepth{1'b0}};
            data_q   <= {(TreeDepth*DataTypeWidth){1'b0}};
            c_cnt_q  <= {CAddrWidth{1'b0}};
            c_addr_q <= {CAddrWidth{1'b0}};
            k_addr_q <= {TreeDepth{1'b0}};
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            for (int i = 0; i < NumThr; i++) begin
                thr_q[i] <= {DataTypeWidth{1'b0}};
            end
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            node_q   <= node_d;
            kbits_q  <= kbits_d;
            data_q   <= data_d;
            c_cnt_q  <= c_cnt_d;
            c_addr_q <= c_addr_d;
            k_addr_q <= k_addr_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            for (int i = 0; i < NumThr; i++) begin
                thr_q[i] <= thr_d[i];
            end
        end
    end

    assign ready_o  = ready_s;
    assign c_addr_o = c_addr_q;
    assign k_addr_o = k_addr_q;
    assign valid_o  = valid_q;
    assign last_o   = last_q;

endmodule

// File: tb/tb_halut_encoder.sv
// Scoreboard bench for halut_encoder: a real-arithmetic tree-walk model predicts each
// emitted (codebook, index, last, cycle) tuple; a monitor pops and compares on valid_o.
module tb_halut_encoder;

    localparam int K  = 16;
    localparam int C  = 32;
    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [8:0]  waddr_i = '0;
    logic [15:0] wdata_i = '0;
    logic        we_i = 1'b0;
    logic        en_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [63:0] data_i = '0;
    logic [4:0]  c_addr_o;
    logic [3:0]  k_addr_o;
    logic        valid_o;
    logic        last_o;

    typedef struct {
        int     c;
        int     k;
        bit     last;
        longint due;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] thr_m [C*K];
    int          c_next = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    longint      cyc = 0;
    int          last_wait = 0;

    halut_encoder dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .waddr_i  (waddr_i),
        .wdata_i  (wdata_i),
        .we_i     (we_i),
        .en_i     (en_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .data_i   (data_i),
        .c_addr_o (c_addr_o),
        .k_addr_o (k_addr_o),
        .valid_o  (valid_o),
        .last_o   (last_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input bit ok, input string name, input longint act, input longint req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic bit is_nan(input logic [15:0] h);
        return (h[14:10] == 5'h1f) && (h[9:0] != 10'h000);
    endfunction

    // FP16 value as a real; infinities become a huge finite magnitude (still ordered).
    function automatic real fp2r(input logic [15:0] h);
        int  e;
        int  m;
        real v;
        e = int'(h[14:10]);
        m = int'(h[9:0]);
        if (e == 31)     v = 1.0e30;
        else if (e == 0) v = real'(m) / 16777216.0;
        else             v = real'(1024 + m) * (2.0 ** (e - 25));
        return h[15] ? -v : v;
    endfunction

    function automatic bit ref_gt(input logic [15:0] x, input logic [15:0] t);
        if (is_nan(x) || is_nan(t)) return 1'b0;
        return fp2r(x) > fp2r(t);
    endfunction

    function automatic int model_k(input int c, input logic [63:0] d);
        int node = 0;
        int k = 0;
        for (int l = 0; l < TD; l++) begin
            bit b;
            b = ref_gt(d[l*16 +: 16], thr_m[c*K + node]);
            k = k * 2 + int'(b);
            node = 2 * node + 1 + int'(b);
        end
        return k;
    endfunction

    function automatic logic [15:0] rand_fp();
        case ($urandom_range(0, 13))
            0:  return 16'h0000;
            1:  return 16'h8000;
            2:  return 16'h3C00;
            3:  return 16'hBC00;
            4:  return 16'h7C00;
            5:  return 16'hFC00;
            6:  return 16'h7E00;
            7:  return 16'h0001;
            8:  return 16'h8001;
            9:  return 16'h3800;
            10: return 16'h4000;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [63:0] rand_vec();
        return {rand_fp(), rand_fp(), rand_fp(), rand_fp()};
    endfunction

    task automatic write_thr(input int c, input int node, input logic [15:0] v);
        @(negedge clk);
        we_i = 1'b1; waddr_i = 9'(c*K + node); wdata_i = v;
        @(posedge clk); #1;
        we_i = 1'b0;
        thr_m[c*K + node] = v;
    endtask

    // Offers a vector, waits for ready_o, and queues the model's prediction at accept.
    task automatic send_vec(input logic [63:0] d);
        int   waited = 0;
        exp_t e;
        @(negedge clk);
        valid_i = 1'b1; data_i = d; #1;
        while (!ready_o && waited < 20) begin
            @(negedge clk); #1;
            waited++;
        end
        if (!ready_o) begin
            check(1'b0, "ready_timeout", 0, 1);
            valid_i = 1'b0;
        end else begin
            e.c = c_next; e.k = model_k(c_next, d); e.last = (c_next == C-1); e.due = cyc + 1 + TD;
            sb.push_back(e);
            c_next = (c_next + 1) % C;
            last_wait = waited;
            @(posedge clk); #1;
            valid_i = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(sb.size() == 0, "drain_empty", sb.size(), 0);
        @(negedge clk);
    endtask

    task automatic pulse_en_low();
        @(negedge clk); en_i = 1'b0;
        @(negedge clk); en_i = 1'b1;
        c_next = 0;
    endtask

    // Monitor: every emitted codebook must match the head of the scoreboard.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_ni) begin
                if (valid_o) begin
                    if (sb.size() == 0) begin
                        check(1'b0, "unexpected_valid", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check(c_addr_o == 5'(e.c), "c_addr", c_addr_o, e.c);
                        check(k_addr_o == 4'(e.k), "k_addr", k_addr_o, e.k);
                        check(last_o == e.last, "last", last_o, e.last);
                        check(cyc == e.due, "latency_cycle", cyc, e.due);
                    end
                end else begin
                    check(last_o == 1'b0, "last_without_valid", last_o, 0);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        for (int i = 0; i < C*K; i++) thr_m[i] = 16'h0000;

        // Reset with en_i high: outputs must be zero; ready_o follows en_i afterwards.
        repeat (3) @(negedge clk);
        check(valid_o == 1'b0, "rst_valid", valid_o, 0);
        check(c_addr_o == 5'd0, "rst_c_addr", c_addr_o, 0);
        check(k_addr_o == 4'd0, "rst_k_addr", k_addr_o, 0);
        rst_ni = 1'b1;
        #1;
        check(ready_o == 1'b1, "ready_after_reset", ready_o, 1);
        en_i = 1'b0; #1;
        check(ready_o == 1'b0, "ready_en_low", ready_o, 0);
        en_i = 1'b1;

        // Zero thresholds: +1.0 goes right everywhere, -1.0 left everywhere.
        send_vec({4{16'h3C00}});
        send_vec({4{16'hBC00}});
        drain();

        // Path 0 -> 2 -> 5 -> 12 on codebook 0, expected index 0b1010.
        pulse_en_low();
        write_thr(0, 0, 16'h3800);
        write_thr(0, 2, 16'h4000);
        write_thr(0, 5, 16'h0000);
        write_thr(0, 12, 16'h3C00);
        send_vec({4{16'h3C00}});
        // FP corners against zero thresholds on codebooks 1..4.
        send_vec({4{16'h8000}});
        send_vec({4{16'h7E00}});
        send_vec({4{16'h7C00}});
        send_vec({4{16'h0001}});
        drain();

        // Random thresholds everywhere, then a 33-vector back-to-back stream from c=0.
        for (int c = 0; c < C; c++)
            for (int n = 0; n < K-1; n++)
                write_thr(c, n, rand_fp());
        pulse_en_low();
        for (int v = 0; v < 33; v++) begin
            send_vec(rand_vec());
            if (v != 0) check(last_wait == TD-1, "stream_ready_spacing", last_wait, TD-1);
        end
        drain();

        // Abort codebook 5 at level 2; the next vector restarts at codebook 0.
        pulse_en_low();
        for (int v = 0; v < 6; v++) begin
            send_vec(rand_vec());
            if (v != 0) check(last_wait == TD-1, "abort_ready_spacing", last_wait, TD-1);
        end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); #1;
        en_i = 1'b0;
        check(sb.size() == 1, "abort_inflight", sb.size(), 1);
        if (sb.size() != 0) void'(sb.pop_back());
        @(negedge clk); en_i = 1'b1;
        c_next = 0;
        repeat (3) @(negedge clk);
        send_vec(rand_vec());

        // Random vectors with random idle gaps between them.
        for (int v = 0; v < 40; v++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_vec(rand_vec());
        end
        drain();

        // Asynchronous reset mid-walk clears state and thresholds immediately.
        send_vec(rand_vec());
        @(negedge clk); #2;
        rst_ni = 1'b0; #1;
        check(ready_o == 1'b1, "async_rst_to_idle", ready_o, 1);
        check(valid_o == 1'b0, "async_rst_valid", valid_o, 0);
        sb.delete();
        c_next = 0;
        for (int i = 0; i < C*K; i++) thr_m[i] = 16'h0000;
        @(negedge clk); rst_ni = 1'b1;
        send_vec({4{16'h3C00}});
        send_vec({4{16'h3C00}});
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
